sdrc_wb_arb: RTL and testbench



---
 rtl/sdrc_arb_pkg.sv | 19 +
 rtl/sdrc_rr_pick.sv | 41 ++++
 rtl/sdrc_wb_arb.sv | 168 ++++++++++++++++
 tb/tb_sdrc_wb_arb.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_arb_pkg.sv
// Shared types and constants for the SDRAM-controller Wishbone arbiter.
//   arb_state_t : arbiter FSM states
//   CTI_*       : Wishbone cycle-type identifiers seen on the master ports
//   WD_W        : width of the stall watchdog counter
package sdrc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int WD_W = 16;

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin picker: rotates the request vector so the search
// starts just after the previous winner, then takes the nearest requester.
//   req  : NM request bits
//   last : index of the previous winner
//   gnt  : one-hot winner (all zero when nothing is requested)
//   idx  : index of the winner (0 when nothing is requested)
module sdrc_rr_pick
    import sdrc_arb_pkg::*;
#(
    parameter int NM = 4,
    parameter int IW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx
);

    // cand[gi] is the master sitting gi+1 places after the previous winner.
    logic [IW-1:0] cand [NM];

    for (genvar gi = 0; gi < NM; gi++) begin : g_cand
        assign cand[gi] = IW'((int'(last) + gi + 1) % NM);
    end

    always_comb begin
        gnt = '0;
        idx = '0;
        // Walk from the farthest candidate to the nearest; the nearest
        // requester is written last and therefore wins.
        for (int i = NM - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                idx = cand[i];
            end
        end
        if (|req) begin
            gnt = NM'(1) << idx;
        end
    end

endmodule

// File: rtl/sdrc_wb_arb.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller's slave port.
// Ownership is held for the whole Wishbone cycle (bursts are never split);
// a stall watchdog aborts a cycle that waits TO_CYCLES without an ack.
//   wb_clk_i / wb_rst_i : clock, asynchronous active-high reset
//   m_*_i               : packed per-master Wishbone master signals
//   m_ack_o / m_err_o   : per-master acknowledge / watchdog error
//   m_dat_o             : read data broadcast to every master
//   s_*                 : single Wishbone port toward the controller
//   gnt_o               : one-hot current owner (status)
module sdrc_wb_arb
    import sdrc_arb_pkg::*;
#(
    parameter int NM        = 4,
    parameter int dw        = 32,
    parameter int APP_AW    = 26,
    parameter int TO_CYCLES = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NM-1:0]          m_cyc_i,
    input  logic [NM-1:0]          m_stb_i,
    input  logic [NM-1:0]          m_we_i,
    input  logic [NM*APP_AW-1:0]   m_adr_i,
    input  logic [NM*dw-1:0]       m_dat_i,
    input  logic [NM*(dw/8)-1:0]   m_sel_i,
    input  logic [NM*3-1:0]        m_cti_i,
    output logic [NM-1:0]          m_ack_o,
    output logic [NM-1:0]          m_err_o,
    output logic [dw-1:0]          m_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [APP_AW-1:0]      s_adr_o,
    output logic [dw-1:0]          s_dat_o,
    output logic [dw/8-1:0]        s_sel_o,
    output logic [2:0]             s_cti_o,
    input  logic                   s_ack_i,
    input  logic [dw-1:0]          s_dat_i,
    output logic [NM-1:0]          gnt_o
);

    localparam int IW = $clog2(NM);
    localparam int SW = dw / 8;
    // Expiry fires in the stalled cycle that would bring the count to TO_CYCLES.
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TO_CYCLES - 1);

    arb_state_t      state_q, state_d;
    logic [NM-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic [NM-1:0]   pick_gnt;
    logic [IW-1:0]   pick_idx;

    // Unpacked views of the packed master buses.
    logic [APP_AW-1:0] adr_a [NM];
    logic [dw-1:0]     dat_a [NM];
    logic [SW-1:0]     sel_a [NM];
    logic [2:0]        cti_a [NM];

    for (genvar gi = 0; gi < NM; gi++) begin : g_unpack
        assign adr_a[gi] = m_adr_i[gi*APP_AW +: APP_AW];
        assign dat_a[gi] = m_dat_i[gi*dw +: dw];
        assign sel_a[gi] = m_sel_i[gi*SW +: SW];
        assign cti_a[gi] = m_cti_i[gi*3 +: 3];
    end

    sdrc_rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // last_q always holds the current owner's index while BUSY/ABORT.
    logic cyc_g, stb_g;
    assign cyc_g = m_cyc_i[last_q];
    assign stb_g = m_stb_i[last_q];

    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NM - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wd_d    = wd_q;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        m_ack_o = '0;
        m_err_o = '0;

        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (|m_cyc_i) begin
                    gnt_d   = pick_gnt;
                    last_d  = pick_idx;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                s_cyc_o = cyc_g;
                s_stb_o = stb_g;
                s_we_o  = m_we_i[last_q];
                s_adr_o = adr_a[last_q];
                s_dat_o = dat_a[last_q];
                s_sel_o = sel_a[last_q];
                s_cti_o = cti_a[last_q];
                m_ack_o = s_ack_i ? gnt_q : '0;

                if (!cyc_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    wd_d    = '0;
                end else if (stb_g && !s_ack_i) begin
                    // A stalled cycle; an ack in the same cycle never expires.
                    if (wd_q >= WD_LIMIT) begin
                        m_err_o = gnt_q;
                        state_d = ABORT;
                        wd_d    = '0;
                    end else if (wd_q != '1) begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end else begin
                    wd_d = '0;
                end
            end

            ABORT: begin
                // Slave side stays idle until the aborted master lets go.
                if (!cyc_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdrc_wb_arb.sv
// Self-checking bench for sdrc_wb_arb (NM=4, TO_CYCLES=16): a vector table for
// the single-master and rotation cases, hand sequences for burst hold,
// watchdog, ack/timeout race and mid-burst reset, then randomized traffic
// against a behavioural model of the arbitration rules.
module tb_sdrc_wb_arb;
    import sdrc_arb_pkg::*;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 26;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     m_cyc = '0, m_stb = '0, m_we = '0;
    logic [NM*AW-1:0]  m_adr = '0;
    logic [NM*DW-1:0]  m_dat = '0;
    logic [NM*SW-1:0]  m_sel = '0;
    logic [NM*3-1:0]   m_cti = '0;
    logic [NM-1:0]     m_ack, m_err, gnt;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat;
    logic [SW-1:0]     s_sel;
    logic [2:0]        s_cti;
    logic              s_ack = 1'b0;
    logic [DW-1:0]     s_dat_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdrc_wb_arb #(
        .NM        (NM),
        .dw        (DW),
        .APP_AW    (AW),
        .TO_CYCLES (TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_sel_i  (m_sel),
        .m_cti_i  (m_cti),
        .m_ack_o  (m_ack),
        .m_err_o  (m_err),
        .m_dat_o  (m_dat_o),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_dat),
        .s_sel_o  (s_sel),
        .s_cti_o  (s_cti),
        .s_ack_i  (s_ack),
        .s_dat_i  (s_dat_i),
        .gnt_o    (gnt)
    );

    typedef struct {
        logic          rst;
        logic [NM-1:0] cyc;
        logic [NM-1:0] stb;
        logic          ack;
        logic [NM-1:0] e_gnt;
        logic          e_scyc;
        logic [NM-1:0] e_ack;
        logic [NM-1:0] e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [NM-1:0] c, input logic [NM-1:0] s,
                       input logic a, input logic [NM-1:0] eg, input logic esc,
                       input logic [NM-1:0] ea, input logic [NM-1:0] ee);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.ack = a;
        v.e_gnt = eg; v.e_scyc = esc; v.e_ack = ea; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        m_cyc = '0;
        m_stb = '0;
        m_cti = '0;
        s_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic int ohidx(input logic [NM-1:0] v);
        int r = 0;
        for (int i = 0; i < NM; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [AW-1:0] adr_of(input int k);
        return m_adr[k*AW +: AW];
    endfunction

    // Behavioural reference model state.
    int            mod_owner;
    int            mod_last;
    int            mod_stall;
    bit            mod_abort;
    logic [NM-1:0] e_gnt, e_ack, e_err;
    logic          e_scyc, e_stb, e_we, expire, live, found;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic [2:0]    e_cti;

    initial begin
        // ---- vector table: single master, then four-way rotation ----
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(0, 4'b0100, 4'b0100, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0000, 4'b0000);
        add(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0000, 4'b0000);
        add(0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 4'b0100, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 4'b0100, 0, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 4'b0000);
        add(0, 4'b1110, 4'b1111, 0, 4'b0001, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 4'b0010, 4'b0000);
        add(0, 4'b1101, 4'b1111, 0, 4'b0010, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 4'b0100, 4'b0000);
        add(0, 4'b1011, 4'b1111, 0, 4'b0100, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 4'b1000, 4'b0000);
        add(0, 4'b0111, 4'b1111, 0, 4'b1000, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 4'b0000);
        add(0, 4'b1110, 4'b1111, 0, 4'b0001, 0, 4'b0000, 4'b0000);

        for (int k = 0; k < NM; k++) begin
            m_adr[k*AW +: AW] = AW'(32'h0010_0000 * (k + 1) + 32'h40 * k);
            m_dat[k*DW +: DW] = 32'hA000_0000 + 32'(k);
            m_sel[k*SW +: SW] = SW'(k + 1);
        end

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            rst   = vecs[i].rst;
            m_cyc = vecs[i].cyc;
            m_stb = vecs[i].stb;
            s_ack = vecs[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), 64'(gnt), 64'(vecs[i].e_gnt));
            check($sformatf("vec%0d_scyc", i), 64'(s_cyc), 64'(vecs[i].e_scyc));
            check($sformatf("vec%0d_ack", i), 64'(m_ack), 64'(vecs[i].e_ack));
            check($sformatf("vec%0d_err", i), 64'(m_err), 64'(vecs[i].e_err));
            if (vecs[i].e_gnt != '0)
                check($sformatf("vec%0d_adr", i), 64'(s_adr), 64'(adr_of(ohidx(vecs[i].e_gnt))));
            $display("vec %0d: rst=%b cyc=%b ack_i=%b -> gnt=%b s_cyc=%b m_ack=%b",
                     i, rst, m_cyc, s_ack, gnt, s_cyc, m_ack);
            step();
        end

        // ---- burst hold: master 1 keeps the port for 8 beats ----
        do_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        m_cti[3 +: 3] = CTI_INCR;
        @(negedge clk);
        check("burst_idle_gnt", 64'(gnt), 64'(4'b0000));
        step();
        m_cyc = 4'b0011; m_stb = 4'b0011;
        s_ack = 1'b1;
        for (int b = 0; b < 8; b++) begin
            m_cti[3 +: 3] = (b == 7) ? CTI_EOB : CTI_INCR;
            m_adr[AW +: AW] = AW'(32'h0020_0000 + 32'(4 * b));
            @(negedge clk);
            check("burst_gnt", 64'(gnt), 64'(4'b0010));
            check("burst_ack", 64'(m_ack), 64'(4'b0010));
            check("burst_cti", 64'(s_cti), 64'((b == 7) ? CTI_EOB : CTI_INCR));
            check("burst_adr", 64'(s_adr), 64'(32'h0020_0000 + 32'(4 * b)));
            $display("burst beat %0d: gnt=%b m_ack=%b cti=%b adr=%h", b, gnt, m_ack, s_cti, s_adr);
            step();
        end
        s_ack = 1'b0;
        m_cyc = 4'b0001; m_stb = 4'b0001;
        @(negedge clk);
        check("burst_rel_gnt", 64'(gnt), 64'(4'b0010));
        step();
        @(negedge clk);
        check("burst_dead_gnt", 64'(gnt), 64'(4'b0000));
        step();
        @(negedge clk);
        check("burst_next_gnt", 64'(gnt), 64'(4'b0001));
        check("burst_next_scyc", 64'(s_cyc), 64'(1'b1));
        $display("burst handover: master 0 granted gnt=%b", gnt);
        step();

        // ---- watchdog: master 3 never acked ----
        do_reset();
        m_cyc = 4'b1000; m_stb = 4'b1000;
        @(negedge clk);
        check("wd_idle_gnt", 64'(gnt), 64'(4'b0000));
        step();
        m_cyc = 4'b1001; m_stb = 4'b1001;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            check($sformatf("wd_err_c%0d", c), 64'(m_err), 64'((c == TO) ? 4'b1000 : 4'b0000));
            check("wd_scyc", 64'(s_cyc), 64'(1'b1));
            step();
        end
        s_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("wd_abort_scyc", 64'(s_cyc), 64'(1'b0));
            check("wd_abort_stb", 64'(s_stb), 64'(1'b0));
            check("wd_abort_gnt", 64'(gnt), 64'(4'b1000));
            check("wd_abort_ack", 64'(m_ack), 64'(4'b0000));
            check("wd_abort_err", 64'(m_err), 64'(4'b0000));
            step();
        end
        m_cyc = 4'b0001; m_stb = 4'b0001;
        @(negedge clk);
        check("wd_drop_gnt", 64'(gnt), 64'(4'b1000));
        step();
        @(negedge clk);
        check("wd_idle2_gnt", 64'(gnt), 64'(4'b0000));
        step();
        @(negedge clk);
        check("wd_next_gnt", 64'(gnt), 64'(4'b0001));
        check("wd_next_ack", 64'(m_ack), 64'(4'b0001));
        $display("watchdog: master 3 aborted, master 0 granted gnt=%b", gnt);
        step();

        // ---- ack arrives exactly in the expiry cycle ----
        do_reset();
        m_cyc = 4'b0100; m_stb = 4'b0100;
        @(negedge clk);
        step();
        for (int c = 1; c < TO; c++) begin
            @(negedge clk);
            check("race_pre_err", 64'(m_err), 64'(4'b0000));
            step();
        end
        s_ack = 1'b1;
        @(negedge clk);
        check("race_ack", 64'(m_ack), 64'(4'b0100));
        check("race_err", 64'(m_err), 64'(4'b0000));
        step();
        s_ack = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            check($sformatf("race_post_err_c%0d", c), 64'(m_err), 64'((c == TO) ? 4'b0100 : 4'b0000));
            check("race_post_scyc", 64'(s_cyc), 64'(1'b1));
            step();
        end
        $display("race: ack won, watchdog restarted and expired after %0d more stalls", TO);

        // ---- reset asserted in the middle of a burst ----
        do_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        m_cti[3 +: 3] = CTI_INCR;
        @(negedge clk);
        step();
        s_ack = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check("mrst_beat_ack", 64'(m_ack), 64'(4'b0010));
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check("mrst_gnt", 64'(gnt), 64'(4'b0000));
        check("mrst_scyc", 64'(s_cyc), 64'(1'b0));
        check("mrst_stb", 64'(s_stb), 64'(1'b0));
        check("mrst_ack", 64'(m_ack), 64'(4'b0000));
        check("mrst_adr", 64'(s_adr), 64'(0));
        step();
        rst = 1'b0;
        s_ack = 1'b0;
        m_cyc = 4'b1111; m_stb = 4'b1111;
        @(negedge clk);
        check("mrst_idle_gnt", 64'(gnt), 64'(4'b0000));
        step();
        @(negedge clk);
        check("mrst_first_gnt", 64'(gnt), 64'(4'b0001));
        $display("mid-burst reset: after release gnt=%b", gnt);
        step();

        // ---- randomized traffic against the reference model ----
        do_reset();
        mod_owner = -1;
        mod_last  = NM - 1;
        mod_stall = 0;
        mod_abort = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(15) == 0) m_cyc[k] = ~m_cyc[k];
                m_stb[k] = ($urandom_range(3) != 0);
                m_we[k]  = 1'($urandom_range(1));
                m_adr[k*AW +: AW] = AW'($urandom);
                m_dat[k*DW +: DW] = $urandom;
                m_sel[k*SW +: SW] = SW'($urandom);
                m_cti[k*3 +: 3]   = 3'($urandom);
            end
            s_ack   = (((t / 64) % 3) != 0) && ($urandom_range(2) == 0);
            s_dat_i = $urandom;
            @(negedge clk);

            // Expected outputs for this cycle.
            e_gnt = '0; e_ack = '0; e_err = '0;
            e_scyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; expire = 1'b0;
            e_adr = '0; e_dat = '0; e_sel = '0; e_cti = '0;
            live = (mod_owner >= 0) && !mod_abort;
            if (mod_owner >= 0) e_gnt[mod_owner] = 1'b1;
            if (live) begin
                e_scyc = m_cyc[mod_owner];
                e_stb  = m_stb[mod_owner];
                e_we   = m_we[mod_owner];
                e_adr  = m_adr[mod_owner*AW +: AW];
                e_dat  = m_dat[mod_owner*DW +: DW];
                e_sel  = m_sel[mod_owner*SW +: SW];
                e_cti  = m_cti[mod_owner*3 +: 3];
                if (s_ack) e_ack[mod_owner] = 1'b1;
                expire = m_cyc[mod_owner] && m_stb[mod_owner] && !s_ack && (mod_stall + 1 >= TO);
                if (expire) e_err[mod_owner] = 1'b1;
            end
            check("rnd_gnt",  64'(gnt),     64'(e_gnt));
            check("rnd_scyc", 64'(s_cyc),   64'(e_scyc));
            check("rnd_sstb", 64'(s_stb),   64'(e_stb));
            check("rnd_swe",  64'(s_we),    64'(e_we));
            check("rnd_sadr", 64'(s_adr),   64'(e_adr));
            check("rnd_sdat", 64'(s_dat),   64'(e_dat));
            check("rnd_ssel", 64'(s_sel),   64'(e_sel));
            check("rnd_scti", 64'(s_cti),   64'(e_cti));
            check("rnd_mack", 64'(m_ack),   64'(e_ack));
            check("rnd_merr", 64'(m_err),   64'(e_err));
            check("rnd_mdat", 64'(m_dat_o), 64'(s_dat_i));
            if (e_ack != '0 || e_err != '0)
                $display("rnd t=%0d: master %0d %s adr=%h", t, mod_owner,
                         (e_err != '0) ? "watchdog abort" : "ack", e_adr);

            // Advance the model by one clock.
            if (mod_owner < 0) begin
                found = 1'b0;
                for (int i = 1; i <= NM; i++) begin
                    if (!found && m_cyc[(mod_last + i) % NM]) begin
                        found     = 1'b1;
                        mod_owner = (mod_last + i) % NM;
                    end
                end
                if (found) begin
                    mod_last  = mod_owner;
                    mod_stall = 0;
                end
            end else if (!m_cyc[mod_owner]) begin
                mod_owner = -1;
                mod_abort = 1'b0;
                mod_stall = 0;
            end else if (!mod_abort) begin
                if (expire) begin
                    mod_abort = 1'b1;
                    mod_stall = 0;
                end else if (m_stb[mod_owner] && !s_ack) begin
                    mod_stall++;
                end else begin
                    mod_stall = 0;
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
